// File: rtl/bus_datapath.sv
// Single-bus datapath: register file, ALU with A/B/result latches, Z/C flags and PC,
// driven by a built-in read-A / read-B / execute / write-back sequencer.
// Optional build macro BUS_DATAPATH_R0_ZERO_EN: hardwires reg[0] to zero.
module bus_datapath #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4,
  localparam int SEL_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [SEL_W-1:0]  src_a,
  input  logic [SEL_W-1:0]  src_b,
  input  logic [SEL_W-1:0]  dst,
  input  logic              imm_en,
  input  logic [DATA_W-1:0] imm,
  output logic              busy,
  output logic              done,
  input  logic              ext_wr_en,
  input  logic [SEL_W-1:0]  ext_wr_sel,
  input  logic [DATA_W-1:0] ext_wr_data,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] rd_data,
  input  logic              pc_load,
  input  logic [DATA_W-1:0] pc_din,
  input  logic              pc_inc,
  output logic [DATA_W-1:0] pc_out,
  output logic              flag_z,
  output logic              flag_c
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, WRITE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   a_q, b_q, res_q, imm_q;
  logic [2:0]          op_q;
  logic [SEL_W-1:0]    src_a_q, src_b_q, dst_q;
  logic                imm_en_q;
  logic [DATA_W-1:0]   bus;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;

  // Out-of-range selects read as zero; reg[0] optionally reads as zero too.
  function automatic logic [DATA_W-1:0] reg_read(input logic [SEL_W-1:0] sel);
    if (32'(sel) >= NUM_REGS) return '0;
`ifdef BUS_DATAPATH_R0_ZERO_EN
    if (sel == '0) return '0;
`endif
    return regs[sel];
  endfunction

  function automatic logic wr_ok(input logic [SEL_W-1:0] sel);
    if (32'(sel) >= NUM_REGS) return 1'b0;
`ifdef BUS_DATAPATH_R0_ZERO_EN
    if (sel == '0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  assign rd_data = reg_read(rd_sel);

  // The internal bus is a plain multiplexer selected by sequencer state.
  always_comb begin
    bus = '0;
    case (state)
      LOAD_A:  bus = reg_read(src_a_q);
      LOAD_B:  bus = imm_en_q ? imm_q : reg_read(src_b_q);
      WRITE:   bus = res_q;
      default: bus = '0;
    endcase
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      3'b000: {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
      3'b001: {alu_c, alu_res} = {1'b0, a_q} - {1'b0, b_q};
      3'b010: alu_res = a_q & b_q;
      3'b011: alu_res = a_q | b_q;
      3'b100: alu_res = a_q ^ b_q;
      3'b101: alu_res = ~a_q;
      3'b110: begin
        alu_res = {a_q[DATA_W-2:0], 1'b0};
        alu_c   = a_q[DATA_W-1];
      end
      3'b111: begin
        alu_res = {1'b0, a_q[DATA_W-1:1]};
        alu_c   = a_q[0];
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      imm_q    <= '0;
      op_q     <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      imm_en_q <= 1'b0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      // NOTE: the register file is architecturally visible and must read 0 after reset, so it is cleared here.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ext_wr_en && wr_ok(ext_wr_sel)) regs[ext_wr_sel] <= ext_wr_data;
          if (start) begin
            op_q     <= op;
            src_a_q  <= src_a;
            src_b_q  <= src_b;
            dst_q    <= dst;
            imm_en_q <= imm_en;
            imm_q    <= imm;
            busy     <= 1'b1;
            state    <= LOAD_A;
          end
        end
        LOAD_A: begin
          a_q   <= bus;
          state <= LOAD_B;
        end
        LOAD_B: begin
          b_q   <= bus;
          state <= EXEC;
        end
        EXEC: begin
          res_q  <= alu_res;
          flag_z <= (alu_res == '0);
          flag_c <= alu_c;
          done   <= 1'b1;
          state  <= WRITE;
        end
        WRITE: begin
          if (wr_ok(dst_q)) regs[dst_q] <= bus;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Load wins over increment; increment wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)          pc_out <= '0;
    else if (pc_load) pc_out <= pc_din;
    else if (pc_inc)  pc_out <= pc_out + 1'b1;
  end

endmodule

// File: tb/tb_bus_datapath.sv
// Directed self-checking bench for bus_datapath (default 16-bit, 4 registers).
// Honours BUS_DATAPATH_R0_ZERO_EN when the design is built with it.
module tb_bus_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [1:0]  src_a, src_b, dst;
  logic        imm_en;
  logic [15:0] imm;
  logic        busy, done;
  logic        ext_wr_en;
  logic [1:0]  ext_wr_sel;
  logic [15:0] ext_wr_data;
  logic [1:0]  rd_sel;
  logic [15:0] rd_data;
  logic        pc_load, pc_inc;
  logic [15:0] pc_din, pc_out;
  logic        flag_z, flag_c;

  int checks = 0;
  int errors = 0;
  int ndone;
  int lat;

  always #5 clk = ~clk;

  bus_datapath #(.DATA_W(16), .NUM_REGS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .dst(dst), .imm_en(imm_en), .imm(imm),
    .busy(busy), .done(done),
    .ext_wr_en(ext_wr_en), .ext_wr_sel(ext_wr_sel), .ext_wr_data(ext_wr_data),
    .rd_sel(rd_sel), .rd_data(rd_data),
    .pc_load(pc_load), .pc_din(pc_din), .pc_inc(pc_inc), .pc_out(pc_out),
    .flag_z(flag_z), .flag_c(flag_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] sel, input logic [15:0] exp);
    rd_sel = sel;
    #1;
    check(tag, {16'h0, rd_data}, {16'h0, exp});
  endtask

  task automatic ext_write(input logic [1:0] sel, input logic [15:0] data);
    ext_wr_en = 1'b1; ext_wr_sel = sel; ext_wr_data = data;
    @(negedge clk);
    ext_wr_en = 1'b0;
  endtask

  // Starts one transfer at a negedge and watches 8 cycles; done should appear at cycle 4.
  task automatic run_op(input logic [2:0] o, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] d, input logic ie, input logic [15:0] iv,
                        input bit retrig, input bit abort);
    op = o; src_a = a; src_b = b; dst = d; imm_en = ie; imm = iv;
    start = 1'b1;
    ndone = 0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = retrig;
        ext_wr_en = 1'b0;
        check("busy_in_op", {31'h0, busy}, 32'h1);
      end
      if (i == 3) begin
        start = 1'b0;
        if (abort) rst = 1'b1;
      end
      if (i == 5) rst = 1'b0;
      if (done) begin
        ndone++;
        if (lat == 0) lat = i;
      end
    end
    check("busy_after_op", {31'h0, busy}, 32'h0);
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        z;
    logic        c;
  } vec_t;

  vec_t vecs [9] = '{
    '{3'b000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1},
    '{3'b001, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0},
    '{3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0},
    '{3'b011, 16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0, 1'b0},
    '{3'b100, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b0},
    '{3'b101, 16'hF0F0, 16'h0FF0, 16'h0F0F, 1'b0, 1'b0},
    '{3'b110, 16'h8001, 16'h0000, 16'h0002, 1'b0, 1'b1},
    '{3'b111, 16'h8001, 16'h0000, 16'h4000, 1'b0, 1'b1},
    '{3'b111, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1}
  };

  logic [15:0] r0_exp;

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0; dst = '0;
    imm_en = 1'b0; imm = '0; ext_wr_en = 1'b0; ext_wr_sel = '0; ext_wr_data = '0;
    rd_sel = '0; pc_load = 1'b0; pc_din = '0; pc_inc = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 4; i++) check_reg("reset_reg", 2'(i), 16'h0000);
    check("reset_pc", {16'h0, pc_out}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_z", {31'h0, flag_z}, 32'h0);
    check("reset_c", {31'h0, flag_c}, 32'h0);

    // ADD r1 + r2 -> r3
    ext_write(2'd1, 16'h0005);
    ext_write(2'd2, 16'h0003);
    run_op(3'b000, 2'd1, 2'd2, 2'd3, 1'b0, 16'h0, 1'b0, 1'b0);
    check("add_latency", lat, 4);
    check("add_ndone", ndone, 1);
    check_reg("add_r3", 2'd3, 16'h0008);
    check("add_z", {31'h0, flag_z}, 32'h0);
    check("add_c", {31'h0, flag_c}, 32'h0);

    // SUB r2 - r1 -> r0 (borrow)
`ifdef BUS_DATAPATH_R0_ZERO_EN
    r0_exp = 16'h0000;
`else
    r0_exp = 16'hFFFE;
`endif
    run_op(3'b001, 2'd2, 2'd1, 2'd0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("sub_ndone", ndone, 1);
    check_reg("sub_r0", 2'd0, r0_exp);
    check("sub_z", {31'h0, flag_z}, 32'h0);
    check("sub_c", {31'h0, flag_c}, 32'h1);

    // ADD immediate with wrap, start re-asserted while busy
    ext_write(2'd1, 16'hFFFF);
    run_op(3'b000, 2'd1, 2'd0, 2'd1, 1'b1, 16'h0001, 1'b1, 1'b0);
    check("imm_ndone", ndone, 1);
    check_reg("imm_r1", 2'd1, 16'h0000);
    check("imm_z", {31'h0, flag_z}, 32'h1);
    check("imm_c", {31'h0, flag_c}, 32'h1);

    // External write in the same cycle as start: operand sees the new value
    ext_wr_en = 1'b1; ext_wr_sel = 2'd1; ext_wr_data = 16'h0007;
    run_op(3'b000, 2'd1, 2'd0, 2'd2, 1'b1, 16'h0001, 1'b0, 1'b0);
    check_reg("fwd_r2", 2'd2, 16'h0008);

    // Operation table through r1, r2 -> r3
    foreach (vecs[k]) begin
      ext_write(2'd1, vecs[k].a);
      ext_write(2'd2, vecs[k].b);
      run_op(vecs[k].o, 2'd1, 2'd2, 2'd3, 1'b0, 16'h0, 1'b0, 1'b0);
      check($sformatf("op%0d_res", k), {16'h0, rd_data_of(2'd3)}, {16'h0, vecs[k].r});
      check($sformatf("op%0d_z", k), {31'h0, flag_z}, {31'h0, vecs[k].z});
      check($sformatf("op%0d_c", k), {31'h0, flag_c}, {31'h0, vecs[k].c});
    end

    // Program counter
    pc_load = 1'b1; pc_din = 16'hFFFE;
    @(negedge clk);
    pc_load = 1'b0;
    check("pc_load", {16'h0, pc_out}, 32'hFFFE);
    pc_inc = 1'b1;
    @(negedge clk);
    check("pc_inc1", {16'h0, pc_out}, 32'hFFFF);
    @(negedge clk);
    check("pc_wrap", {16'h0, pc_out}, 32'h0000);
    pc_load = 1'b1; pc_din = 16'h0010;
    @(negedge clk);
    pc_load = 1'b0; pc_inc = 1'b0;
    check("pc_prio", {16'h0, pc_out}, 32'h0010);

    // Reset during EXEC of r1 + 0 -> r2
    ext_write(2'd1, 16'h1234);
    run_op(3'b000, 2'd1, 2'd0, 2'd2, 1'b1, 16'h0000, 1'b0, 1'b1);
    check("abort_ndone", ndone, 0);
    check_reg("abort_r2", 2'd2, 16'h0000);
    check("abort_pc", {16'h0, pc_out}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [15:0] rd_data_of(input logic [1:0] sel);
    return dut.reg_read(sel);
  endfunction

endmodule
